fetch_stage: RTL and testbench

Instruction fetch stage directly upstream of the decoder that produces instruction_t.
- Owns the PC and issues word requests to instruction memory over a req/gnt/rvalid interface.
- Buffers returned words in a small in-order FIFO and presents {instruction, pc} to decode over a valid/ready handshake.
- Handles branch/jump redirects by flushing buffered and in-flight fetches.

---
 rtl/fetch_stage.sv | 167 ++++++++++++++++
 tb/tb_fetch_stage.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch stage with in-order buffer and redirect flush
//
// Owns the PC and issues word fetches over a req/gnt/rvalid memory interface.
// Returned words are buffered in an in-order FIFO and presented to decode as
// {if_instr_o, if_pc_o} over a valid/ready handshake. A redirect flushes the
// buffer and marks every in-flight response for discard.
//
// Optional build macro: FETCH_MISALIGN_EXC_EN (adds if_misaligned_o).
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   imem_req_o          fetch request (credit limited: outstanding+buffered < FIFO_DEPTH)
//   imem_addr_o         word-aligned fetch address
//   imem_gnt_i          request accepted this cycle
//   imem_rvalid_i       in-order response valid
//   imem_rdata_i        response instruction word
//   redirect_i          flush and restart fetch (highest priority)
//   redirect_pc_i       restart target
//   if_valid_o          instruction available to decode
//   if_ready_i          decode accepts
//   if_instr_o          instruction word (NOP when invalid)
//   if_pc_o             PC of if_instr_o (holds last value when invalid)
//   if_misaligned_o     misaligned-target entry marker (FETCH_MISALIGN_EXC_EN only)
module fetch_stage #(
  parameter int              XLEN       = 32,
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_o,
  output logic [XLEN-1:0] imem_addr_o,
  input  logic            imem_gnt_i,
  input  logic            imem_rvalid_i,
  input  logic [XLEN-1:0] imem_rdata_i,
  input  logic            redirect_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            if_valid_o,
  input  logic            if_ready_i,
  output logic [XLEN-1:0] if_instr_o,
  output logic [XLEN-1:0] if_pc_o
`ifdef FETCH_MISALIGN_EXC_EN
  ,
  output logic            if_misaligned_o
`endif
);

  localparam int              AW              = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW              = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW:0]     DEPTH_W         = (CW+1)'(FIFO_DEPTH);
  localparam logic [XLEN-1:0] NOP_INSTRUCTION = XLEN'(32'h13);

  logic            started;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] last_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   discard;
  logic [CW-1:0]   fifo_count;
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW-1:0]   pq_wr, pq_rd;
  logic [XLEN-1:0] fifo_instr [FIFO_DEPTH];
  logic [XLEN-1:0] fifo_pc    [FIFO_DEPTH];
  logic [XLEN-1:0] pc_queue   [FIFO_DEPTH];

  logic            halted;
  logic            mis_valid;
  logic [XLEN-1:0] mis_pc;

  logic            grant, fifo_empty, push, pop;
  logic [CW-1:0]   outstanding_nxt;

  assign fifo_empty      = (fifo_count == '0);
  assign grant           = imem_req_o & imem_gnt_i;
  // A response is buffered only once every stale (pre-redirect) response has drained.
  assign push            = imem_rvalid_i & (discard == '0) & ~redirect_i;
  assign pop             = ~fifo_empty & if_ready_i;
  assign outstanding_nxt = outstanding + CW'(grant) - CW'(imem_rvalid_i);

  // Credit rule: every issued request already owns a FIFO slot, so rvalid never stalls.
  // started keeps req low while reset is asserted and for the first cycle after release.
  assign imem_req_o  = started & ~halted &
                       (({1'b0, outstanding} + {1'b0, fifo_count}) < DEPTH_W);
  assign imem_addr_o = pc;

  assign if_valid_o  = ~fifo_empty | mis_valid;
  assign if_instr_o  = fifo_empty ? NOP_INSTRUCTION : fifo_instr[rd_ptr];
  assign if_pc_o     = ~fifo_empty ? fifo_pc[rd_ptr] : (mis_valid ? mis_pc : last_pc);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started     <= 1'b0;
      pc          <= {RESET_PC[XLEN-1:2], 2'b00};
      last_pc     <= '0;
      outstanding <= '0;
      discard     <= '0;
      fifo_count  <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      pq_wr       <= '0;
      pq_rd       <= '0;
    end else begin
      started     <= 1'b1;
      last_pc     <= if_pc_o;
      outstanding <= outstanding_nxt;
      // The PC queue tracks every issued request, discarded or not, so it is never flushed.
      if (grant)         pq_wr <= pq_wr + AW'(1);
      if (imem_rvalid_i) pq_rd <= pq_rd + AW'(1);
      if (redirect_i) begin
        pc         <= {redirect_pc_i[XLEN-1:2], 2'b00};
        // Includes a same-cycle grant (old address) and excludes a same-cycle response.
        discard    <= outstanding_nxt;
        fifo_count <= '0;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
      end else begin
        if (grant) pc <= pc + XLEN'(4);
        if (imem_rvalid_i && discard != '0) discard <= discard - CW'(1);
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop)  rd_ptr <= rd_ptr + AW'(1);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (grant) pc_queue[pq_wr] <= imem_addr_o;
    if (push) begin
      fifo_instr[wr_ptr] <= imem_rdata_i;
      fifo_pc[wr_ptr]    <= pc_queue[pq_rd];
    end
  end

`ifdef FETCH_MISALIGN_EXC_EN
  logic mis_pending;

  // A misaligned target halts fetch; once in-flight responses have drained a single
  // marker entry carrying the raw target is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      halted      <= 1'b0;
      mis_pending <= 1'b0;
      mis_valid   <= 1'b0;
      mis_pc      <= '0;
    end else if (redirect_i) begin
      halted      <= |redirect_pc_i[1:0];
      mis_pending <= |redirect_pc_i[1:0];
      mis_valid   <= 1'b0;
      mis_pc      <= redirect_pc_i;
    end else if (mis_pending && outstanding == '0) begin
      mis_pending <= 1'b0;
      mis_valid   <= 1'b1;
    end else if (mis_valid && if_ready_i) begin
      mis_valid   <= 1'b0;
    end
  end

  assign if_misaligned_o = mis_valid & fifo_empty;
`else
  logic unused_low_bits;

  assign unused_low_bits = ^redirect_pc_i[1:0];
  assign halted          = 1'b0;
  assign mis_valid       = 1'b0;
  assign mis_pc          = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb/tb_fetch_stage.sv - randomized self-checking bench for fetch_stage
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        if_valid_o;
  logic        if_ready_i;
  logic [31:0] if_instr_o;
  logic [31:0] if_pc_o;

  always #5 clk = ~clk;

  fetch_stage #(.XLEN(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i),
    .if_valid_o(if_valid_o), .if_ready_i(if_ready_i),
    .if_instr_o(if_instr_o), .if_pc_o(if_pc_o)
  );

  int vectors = 0;
  int errors  = 0;

  // Memory model: in-order responses with random latency.
  int          cyc;
  int          gnt_pct, lat_min, lat_max, last_due;
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  logic [31:0] gaddr_q[$];

  // Scoreboard: after a redirect to T, decode must see T, T+4, T+8, ... in order.
  logic [31:0] model_pc;
  logic [31:0] exp_pc_q[$], exp_instr_q[$], obs_pc_q[$], obs_instr_q[$];
  int          first_req_cyc, first_valid_cyc, stable_viol;
  bit          prev_stall;
  logic [31:0] prev_pc, prev_instr;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1234_5670;
  endfunction

  task automatic clear_model();
    mq_addr.delete(); mq_due.delete(); gaddr_q.delete();
    exp_pc_q.delete(); exp_instr_q.delete(); obs_pc_q.delete(); obs_instr_q.delete();
    model_pc = 32'h0; last_due = -1; cyc = 0;
    first_req_cyc = -1; first_valid_cyc = -1; stable_viol = 0; prev_stall = 0;
  endtask

  task automatic idle_inputs();
    imem_gnt_i = 0; imem_rvalid_i = 0; imem_rdata_i = 0;
    redirect_i = 0; redirect_pc_i = 0; if_ready_i = 0;
  endtask

  task automatic apply_reset();
    rst_n = 0;
    idle_inputs();
    clear_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  // One cycle: drive inputs at the negedge, book-keep what the next posedge commits.
  task automatic step(input bit ready, input bit redir, input logic [31:0] target);
    int  lat;
    bit  gnt;
    gnt = ($urandom_range(99, 0) < gnt_pct);
    imem_gnt_i = gnt;
    if (mq_addr.size() > 0 && mq_due[0] <= cyc) begin
      imem_rvalid_i = 1; imem_rdata_i = mem_word(mq_addr[0]);
      void'(mq_addr.pop_front()); void'(mq_due.pop_front());
    end else begin
      imem_rvalid_i = 0; imem_rdata_i = $urandom;
    end
    if_ready_i = ready; redirect_i = redir; redirect_pc_i = target;
    if (imem_req_o && first_req_cyc < 0) first_req_cyc = cyc;
    if (if_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
    if (imem_req_o && gnt) begin
      lat = $urandom_range(lat_max, lat_min);
      if (cyc + lat <= last_due) last_due = last_due + 1; else last_due = cyc + lat;
      mq_addr.push_back(imem_addr_o); mq_due.push_back(last_due);
      gaddr_q.push_back(imem_addr_o);
    end
    if (prev_stall && (if_valid_o !== 1'b1 || if_pc_o !== prev_pc || if_instr_o !== prev_instr))
      stable_viol++;
    prev_stall = if_valid_o && !ready && !redir;
    prev_pc = if_pc_o; prev_instr = if_instr_o;
    if (if_valid_o && ready) begin
      exp_pc_q.push_back(model_pc); exp_instr_q.push_back(mem_word(model_pc));
      obs_pc_q.push_back(if_pc_o); obs_instr_q.push_back(if_instr_o);
      model_pc = model_pc + 32'd4;
    end
    if (redir) model_pc = {target[31:2], 2'b00};
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 0; idle_inputs(); clear_model();
    @(negedge clk);
    vectors++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got %b want 0", imem_req_o); end
    vectors++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL reset_addr got %h want 0", imem_addr_o); end
    vectors++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", if_valid_o); end
    vectors++; if (if_instr_o !== 32'h13) begin errors++; $display("FAIL reset_instr got %h want 13", if_instr_o); end
    vectors++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL reset_pc got %h want 0", if_pc_o); end
  endtask

  task automatic test_stream();
    apply_reset(); gnt_pct = 100; lat_min = 1; lat_max = 1;
    repeat (24) step(1'b1, 1'b0, 32'h0);
    vectors++; if (first_req_cyc !== 1) begin errors++; $display("FAIL stream_first_req got %0d want 1", first_req_cyc); end
    vectors++; if (first_valid_cyc !== first_req_cyc + 2) begin errors++; $display("FAIL stream_first_valid got %0d want %0d", first_valid_cyc, first_req_cyc + 2); end
    vectors++; if (obs_pc_q.size() < 8) begin errors++; $display("FAIL stream_count got %0d want >=8", obs_pc_q.size()); end
    foreach (obs_pc_q[i]) begin
      vectors++; if (obs_pc_q[i] !== exp_pc_q[i]) begin errors++; $display("FAIL stream_pc[%0d] got %h want %h", i, obs_pc_q[i], exp_pc_q[i]); end
      vectors++; if (obs_instr_q[i] !== exp_instr_q[i]) begin errors++; $display("FAIL stream_instr[%0d] got %h want %h", i, obs_instr_q[i], exp_instr_q[i]); end
    end
  endtask

  task automatic test_stall();
    apply_reset(); gnt_pct = 100; lat_min = 1; lat_max = 1;
    repeat (12) step(1'b0, 1'b0, 32'h0);
    vectors++; if (gaddr_q.size() !== 2) begin errors++; $display("FAIL stall_grants got %0d want 2", gaddr_q.size()); end
    vectors++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req got %b want 0", imem_req_o); end
    vectors++; if (if_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid got %b want 1", if_valid_o); end
    vectors++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL stall_head_pc got %h want 0", if_pc_o); end
    vectors++; if (if_instr_o !== mem_word(32'h0)) begin errors++; $display("FAIL stall_head_instr got %h want %h", if_instr_o, mem_word(32'h0)); end
    repeat (20) step(1'b1, 1'b0, 32'h0);
    vectors++; if (stable_viol !== 0) begin errors++; $display("FAIL stall_stable got %0d want 0", stable_viol); end
    vectors++; if (obs_pc_q.size() < 6) begin errors++; $display("FAIL stall_count got %0d want >=6", obs_pc_q.size()); end
    foreach (obs_pc_q[i]) begin
      vectors++; if (obs_pc_q[i] !== exp_pc_q[i] || obs_instr_q[i] !== exp_instr_q[i]) begin errors++; $display("FAIL stall_order[%0d] got %h/%h want %h/%h", i, obs_pc_q[i], obs_instr_q[i], exp_pc_q[i], exp_instr_q[i]); end
    end
  endtask

  task automatic test_redirect_inflight();
    int n = 0; int idx;
    apply_reset(); gnt_pct = 100; lat_min = 3; lat_max = 3;
    while (mq_addr.size() < 2 && n < 20) begin step(1'b1, 1'b0, 32'h0); n++; end
    vectors++; if (mq_addr.size() !== 2) begin errors++; $display("FAIL inflight_setup got %0d want 2", mq_addr.size()); end
    step(1'b1, 1'b1, 32'h100);
    idx = obs_pc_q.size();
    repeat (30) step($urandom_range(1, 0) == 1, 1'b0, 32'h0);
    vectors++; if (obs_pc_q.size() <= idx) begin errors++; $display("FAIL inflight_timeout got %0d want >%0d", obs_pc_q.size(), idx); end
    else begin
      vectors++; if (obs_pc_q[idx] !== 32'h100) begin errors++; $display("FAIL inflight_first_pc got %h want 100", obs_pc_q[idx]); end
    end
    foreach (obs_pc_q[i]) begin
      vectors++; if (obs_pc_q[i] !== exp_pc_q[i] || obs_instr_q[i] !== exp_instr_q[i]) begin errors++; $display("FAIL inflight_order[%0d] got %h/%h want %h/%h", i, obs_pc_q[i], obs_instr_q[i], exp_pc_q[i], exp_instr_q[i]); end
    end
  endtask

  task automatic test_redirect_collide();
    int n = 0; int idx; bit found = 0;
    apply_reset(); gnt_pct = 100; lat_min = 1; lat_max = 1;
    while (!found && n < 20) begin
      if (imem_req_o && mq_addr.size() > 0 && mq_due[0] <= cyc) found = 1;
      else begin step(1'b1, 1'b0, 32'h0); n++; end
    end
    vectors++; if (found !== 1'b1) begin errors++; $display("FAIL collide_setup got %b want 1", found); end
    step(1'b1, 1'b1, 32'h200);
    idx = obs_pc_q.size();
    repeat (30) step(1'b1, 1'b0, 32'h0);
    vectors++; if (obs_pc_q.size() <= idx) begin errors++; $display("FAIL collide_timeout got %0d want >%0d", obs_pc_q.size(), idx); end
    else begin
      vectors++; if (obs_pc_q[idx] !== 32'h200) begin errors++; $display("FAIL collide_first_pc got %h want 200", obs_pc_q[idx]); end
    end
    foreach (obs_pc_q[i]) begin
      vectors++; if (obs_pc_q[i] !== exp_pc_q[i] || obs_instr_q[i] !== exp_instr_q[i]) begin errors++; $display("FAIL collide_order[%0d] got %h/%h want %h/%h", i, obs_pc_q[i], obs_instr_q[i], exp_pc_q[i], exp_instr_q[i]); end
    end
  endtask

  task automatic test_misalign();
    int g0; int idx;
    apply_reset(); gnt_pct = 100; lat_min = 1; lat_max = 2;
    repeat (5) step(1'b1, 1'b0, 32'h0);
    step(1'b1, 1'b1, 32'h103);
    g0 = gaddr_q.size(); idx = obs_pc_q.size();
    repeat (20) step(1'b1, 1'b0, 32'h0);
    vectors++; if (gaddr_q.size() <= g0) begin errors++; $display("FAIL misalign_no_req got %0d want >%0d", gaddr_q.size(), g0); end
    else begin
      vectors++; if (gaddr_q[g0] !== 32'h100) begin errors++; $display("FAIL misalign_addr got %h want 100", gaddr_q[g0]); end
    end
    vectors++; if (obs_pc_q.size() <= idx) begin errors++; $display("FAIL misalign_timeout got %0d want >%0d", obs_pc_q.size(), idx); end
    else begin
      vectors++; if (obs_pc_q[idx] !== 32'h100) begin errors++; $display("FAIL misalign_first_pc got %h want 100", obs_pc_q[idx]); end
    end
  endtask

  task automatic test_wrap();
    int k = -1;
    apply_reset(); gnt_pct = 100; lat_min = 1; lat_max = 1;
    step(1'b1, 1'b1, 32'hFFFF_FFF8);
    repeat (20) step(1'b1, 1'b0, 32'h0);
    foreach (gaddr_q[i]) if (k < 0 && gaddr_q[i] == 32'hFFFF_FFFC) k = i;
    vectors++; if (k < 0 || k + 1 >= gaddr_q.size()) begin errors++; $display("FAIL wrap_seen got idx %0d of %0d want valid", k, gaddr_q.size()); end
    else begin
      vectors++; if (gaddr_q[k+1] !== 32'h0) begin errors++; $display("FAIL wrap_addr got %h want 0", gaddr_q[k+1]); end
    end
    vectors++; if (obs_pc_q.size() < 4) begin errors++; $display("FAIL wrap_count got %0d want >=4", obs_pc_q.size()); end
    foreach (obs_pc_q[i]) begin
      vectors++; if (obs_pc_q[i] !== exp_pc_q[i] || obs_instr_q[i] !== exp_instr_q[i]) begin errors++; $display("FAIL wrap_order[%0d] got %h/%h want %h/%h", i, obs_pc_q[i], obs_instr_q[i], exp_pc_q[i], exp_instr_q[i]); end
    end
  endtask

  task automatic test_reset_midstream();
    apply_reset(); gnt_pct = 100; lat_min = 1; lat_max = 3;
    repeat (9) step(1'b0, 1'b0, 32'h0);
    step(1'b0, 1'b1, 32'h0000_4440);
    repeat (2) step(1'b0, 1'b0, 32'h0);
    @(posedge clk);
    #2 rst_n = 0;
    #1;
    vectors++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL midrst_req got %b want 0", imem_req_o); end
    vectors++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL midrst_addr got %h want 0", imem_addr_o); end
    vectors++; if (if_valid_o !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", if_valid_o); end
    vectors++; if (if_instr_o !== 32'h13) begin errors++; $display("FAIL midrst_instr got %h want 13", if_instr_o); end
    vectors++; if (if_pc_o !== 32'h0) begin errors++; $display("FAIL midrst_pc got %h want 0", if_pc_o); end
    idle_inputs(); clear_model();
    @(negedge clk);
    rst_n = 1;
    repeat (20) step(1'b1, 1'b0, 32'h0);
    vectors++; if (obs_pc_q.size() < 4) begin errors++; $display("FAIL midrst_count got %0d want >=4", obs_pc_q.size()); end
    foreach (obs_pc_q[i]) begin
      vectors++; if (obs_pc_q[i] !== exp_pc_q[i] || obs_instr_q[i] !== exp_instr_q[i]) begin errors++; $display("FAIL midrst_order[%0d] got %h/%h want %h/%h", i, obs_pc_q[i], obs_instr_q[i], exp_pc_q[i], exp_instr_q[i]); end
    end
  endtask

  task automatic test_random();
    int bad_align = 0;
    apply_reset(); gnt_pct = 60; lat_min = 1; lat_max = 4;
    for (int i = 0; i < 1500; i++)
      step($urandom_range(3, 0) != 0, $urandom_range(39, 0) == 0, $urandom);
    foreach (gaddr_q[i]) if (gaddr_q[i][1:0] != 2'b00) bad_align++;
    vectors++; if (bad_align !== 0) begin errors++; $display("FAIL random_align got %0d want 0", bad_align); end
    vectors++; if (stable_viol !== 0) begin errors++; $display("FAIL random_stable got %0d want 0", stable_viol); end
    vectors++; if (obs_pc_q.size() < 50) begin errors++; $display("FAIL random_count got %0d want >=50", obs_pc_q.size()); end
    foreach (obs_pc_q[i]) begin
      vectors++; if (obs_pc_q[i] !== exp_pc_q[i] || obs_instr_q[i] !== exp_instr_q[i]) begin errors++; $display("FAIL random_order[%0d] got %h/%h want %h/%h", i, obs_pc_q[i], obs_instr_q[i], exp_pc_q[i], exp_instr_q[i]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    gnt_pct = 100; lat_min = 1; lat_max = 1;
    test_reset();
    test_stream();
    test_stall();
    test_redirect_inflight();
    test_redirect_collide();
    test_misalign();
    test_wrap();
    test_reset_midstream();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
